// File: rtl/pulse_demerge_t.sv
// ---------------------------------------------------------------------------
// pulse_demerge_t
//
// Splits one toggle-encoded pulse stream into two toggle-encoded branches
// (a and b). Each level change on q_in is one pulse. After a start-up window
// of BEGIN_CYC edges, accepted pulses are steered either round-robin or by
// sel. After an accepted pulse, a guard window of MIN_GAP-1 edges rejects
// further pulses. A rejected pulse sets a sticky violation flag and restarts
// the window.
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous, active-high reset
//   q_in      in   toggle-encoded merged pulse stream
//   mode      in   0 = round-robin, 1 = steer by sel
//   sel       in   steering target in mode 1 (0 = a, 1 = b)
//   viol_clr  in   clears the sticky viol flag (a violation on the same edge wins)
//   a_q, b_q  out  toggle-encoded branch streams
//   cnt_a/b   out  saturating count of pulses steered to a / b
//   viol      out  sticky guard-window violation flag
//   viol_cnt  out  saturating count of guard-window violations
//   ready     out  high once start-up has completed (ACTIVE or GUARD)
// ---------------------------------------------------------------------------
module pulse_demerge_t #(
  parameter int unsigned MIN_GAP   = 3,   // legal range 1..15
  parameter int unsigned BEGIN_CYC = 8,   // must be at least 1
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             mode,
  input  logic             sel,
  input  logic             viol_clr,
  output logic             a_q,
  output logic             b_q,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             viol,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             ready
);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_GUARD   = 2'd2
  } state_e;

  // The start-up counter only has to reach BEGIN_CYC-1.
  localparam int unsigned      SU_W       = (BEGIN_CYC > 1) ? $clog2(BEGIN_CYC) : 1;
  localparam logic [SU_W-1:0]  SU_LAST    = SU_W'(BEGIN_CYC - 1);
  localparam logic [3:0]       GUARD_LOAD = 4'(MIN_GAP - 1);
  localparam bit               USE_GUARD  = (MIN_GAP > 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q,    state_d;
  logic [SU_W-1:0]  su_cnt_q,   su_cnt_d;
  logic [3:0]       guard_q,    guard_d;
  logic             q_prev_q,   q_prev_d;
  logic             rr_q,       rr_d;        // 0 = a, 1 = b
  logic             a_tgl_q,    a_tgl_d;
  logic             b_tgl_q,    b_tgl_d;
  logic [CNT_W-1:0] cnt_a_q,    cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q,    cnt_b_d;
  logic             viol_q,     viol_d;
  logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;

  logic pulse;
  logic accept;
  logic drop;
  logic to_b;

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d    = state_q;
    su_cnt_d   = su_cnt_q;
    guard_d    = guard_q;
    q_prev_d   = q_in;
    rr_d       = rr_q;
    a_tgl_d    = a_tgl_q;
    b_tgl_d    = b_tgl_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    viol_d     = viol_q;
    viol_cnt_d = viol_cnt_q;
    accept     = 1'b0;
    drop       = 1'b0;

    pulse = q_in ^ q_prev_q;
    // sel and mode are sampled at the accepting edge itself.
    to_b  = mode ? sel : rr_q;

    unique case (state_q)
      ST_STARTUP: begin
        // Pulses seen here only update q_prev; they are neither steered
        // nor counted as violations.
        if (su_cnt_q == SU_LAST) begin
          state_d = ST_ACTIVE;
        end else begin
          su_cnt_d = su_cnt_q + SU_W'(1);
        end
      end
      ST_ACTIVE: begin
        if (pulse) begin
          accept = 1'b1;
          if (USE_GUARD) begin
            state_d = ST_GUARD;
            guard_d = GUARD_LOAD;
          end
        end
      end
      ST_GUARD: begin
        if (pulse) begin
          // A pulse inside the window restarts the full window.
          drop    = 1'b1;
          guard_d = GUARD_LOAD;
        end else if (guard_q <= 4'd1) begin
          state_d = ST_ACTIVE;
          guard_d = 4'd0;
        end else begin
          guard_d = guard_q - 4'd1;
        end
      end
      default: state_d = ST_STARTUP;
    endcase

    if (accept) begin
      if (to_b) begin
        b_tgl_d = ~b_tgl_q;
        cnt_b_d = sat_inc(cnt_b_q);
      end else begin
        a_tgl_d = ~a_tgl_q;
        cnt_a_d = sat_inc(cnt_a_q);
      end
      // The round-robin pointer is frozen while steering by sel.
      if (!mode) begin
        rr_d = ~rr_q;
      end
    end

    if (drop) begin
      viol_d     = 1'b1;
      viol_cnt_d = sat_inc(viol_cnt_q);
    end else if (viol_clr) begin
      viol_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    if (rst) begin
      state_q    <= ST_STARTUP;
      su_cnt_q   <= '0;
      guard_q    <= '0;
      q_prev_q   <= 1'b0;
      rr_q       <= 1'b0;
      a_tgl_q    <= 1'b0;
      b_tgl_q    <= 1'b0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      viol_q     <= 1'b0;
      viol_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      su_cnt_q   <= su_cnt_d;
      guard_q    <= guard_d;
      q_prev_q   <= q_prev_d;
      rr_q       <= rr_d;
      a_tgl_q    <= a_tgl_d;
      b_tgl_q    <= b_tgl_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      viol_q     <= viol_d;
      viol_cnt_q <= viol_cnt_d;
    end
  end

  assign a_q      = a_tgl_q;
  assign b_q      = b_tgl_q;
  assign cnt_a    = cnt_a_q;
  assign cnt_b    = cnt_b_q;
  assign viol     = viol_q;
  assign viol_cnt = viol_cnt_q;
  assign ready    = (state_q != ST_STARTUP);

endmodule

// File: tb/tb_pulse_demerge_t.sv
// ---------------------------------------------------------------------------
// tb_pulse_demerge_t
//
// Scoreboard bench for pulse_demerge_t. The driver applies one set of inputs
// per cycle, advances a behavioural model and pushes the expected post-edge
// outputs into a queue. An independent monitor pops one entry per cycle on
// the falling edge and compares it with the DUT outputs.
//
// The model works in terms of edge numbers since reset: pulses at edges
// 1..BEGIN_CYC are ignored; afterwards a pulse is accepted only if at least
// MIN_GAP edges have passed since the previous post-start-up pulse (accepted
// or dropped).
// ---------------------------------------------------------------------------
module tb_pulse_demerge_t;

  localparam int MIN_GAP   = 3;
  localparam int BEGIN_CYC = 8;
  localparam int CNT_W     = 4;   // small, so saturation is reachable
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             q_in = 1'b0;
  logic             mode = 1'b0;
  logic             sel = 1'b0;
  logic             viol_clr = 1'b0;
  logic             a_q, b_q, viol, ready;
  logic [CNT_W-1:0] cnt_a, cnt_b, viol_cnt;

  pulse_demerge_t #(
    .MIN_GAP  (MIN_GAP),
    .BEGIN_CYC(BEGIN_CYC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .q_in    (q_in),
    .mode    (mode),
    .sel     (sel),
    .viol_clr(viol_clr),
    .a_q     (a_q),
    .b_q     (b_q),
    .cnt_a   (cnt_a),
    .cnt_b   (cnt_b),
    .viol    (viol),
    .viol_cnt(viol_cnt),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit a;
    bit b;
    int cnt_a;
    int cnt_b;
    bit viol;
    int viol_cnt;
    bit ready;
    int step_no;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit q_lvl    = 1'b0;
  bit m_prev   = 1'b0;
  int m_edge   = 0;
  bit m_has    = 1'b0;
  int m_last   = 0;
  bit m_rr     = 1'b0;
  bit m_a      = 1'b0;
  bit m_b      = 1'b0;
  int m_cnt_a  = 0;
  int m_cnt_b  = 0;
  bit m_viol   = 1'b0;
  int m_vcnt   = 0;
  int step_ctr = 0;

  task automatic check(input string name, input int act, input int req, input int sn);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", name, sn, act, req);
    end
  endtask

  // One clock cycle of stimulus; tog toggles q_in (one pulse).
  task automatic step(input bit r, input bit tog, input bit md, input bit sl, input bit clr);
    exp_t e;
    bit   pulse;
    @(negedge clk);
    #1;
    q_lvl    = q_lvl ^ tog;
    rst      = r;
    q_in     = q_lvl;
    mode     = md;
    sel      = sl;
    viol_clr = clr;

    if (r) begin
      m_prev = 1'b0; m_edge = 0; m_has = 1'b0; m_last = 0; m_rr = 1'b0;
      m_a = 1'b0; m_b = 1'b0; m_cnt_a = 0; m_cnt_b = 0; m_viol = 1'b0; m_vcnt = 0;
    end else begin
      pulse  = (q_lvl != m_prev);
      m_prev = q_lvl;
      m_edge = m_edge + 1;
      if (pulse && m_edge > BEGIN_CYC) begin
        if (m_has && (m_edge - m_last) < MIN_GAP) begin
          m_viol = 1'b1;
          if (m_vcnt < CNT_MAX) m_vcnt++;
        end else begin
          if ((md ? sl : m_rr) == 1'b1) begin
            m_b = ~m_b;
            if (m_cnt_b < CNT_MAX) m_cnt_b++;
          end else begin
            m_a = ~m_a;
            if (m_cnt_a < CNT_MAX) m_cnt_a++;
          end
          if (!md) m_rr = ~m_rr;
          if (clr) m_viol = 1'b0;
        end
        m_has  = 1'b1;
        m_last = m_edge;
      end else if (clr) begin
        m_viol = 1'b0;
      end
    end

    step_ctr++;
    e.a        = m_a;
    e.b        = m_b;
    e.cnt_a    = m_cnt_a;
    e.cnt_b    = m_cnt_b;
    e.viol     = m_viol;
    e.viol_cnt = m_vcnt;
    e.ready    = (m_edge >= BEGIN_CYC);
    e.step_no  = step_ctr;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input bit md, input bit sl);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, md, sl, 1'b0);
  endtask

  // Monitor: each falling edge reflects exactly one rising edge of stimulus.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("a_q",      int'(a_q),      int'(e.a),     e.step_no);
      check("b_q",      int'(b_q),      int'(e.b),     e.step_no);
      check("cnt_a",    int'(cnt_a),    e.cnt_a,       e.step_no);
      check("cnt_b",    int'(cnt_b),    e.cnt_b,       e.step_no);
      check("viol",     int'(viol),     int'(e.viol),  e.step_no);
      check("viol_cnt", int'(viol_cnt), e.viol_cnt,    e.step_no);
      check("ready",    int'(ready),    int'(e.ready), e.step_no);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit md;
    bit sl;

    // Reset with q_in toggled high during reset: absorbed in start-up.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Start-up: toggles at cycles 2 and 5 after release are ignored;
    // ready rises at edge BEGIN_CYC.
    for (int i = 1; i <= 10; i++) step(1'b0, (i == 2 || i == 5), 1'b0, 1'b0, 1'b0);

    // Round-robin: four pulses three cycles apart -> a, b, a, b.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0, 1'b0);
    end
    idle(3, 1'b0, 1'b0);

    // Guard: pulses at t, t+1 (dropped), t+4 (accepted).
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0, 1'b0);
    // Guard: pulses at t, t+1 (dropped), t+3 (dropped, window reloaded).
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0, 1'b0);

    // One more round-robin pulse so the pointer is back at a.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);

    // Steering: mode 1, sel 1, three legal pulses -> only b; then mode 0 -> a.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(2, 1'b1, 1'b1);
    end
    idle(1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);

    // Clear race: violation with viol_clr on the same edge keeps viol set;
    // viol_clr alone on the next edge clears it.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4, 1'b0, 1'b0);

    // Saturation: many legal pulses to a in mode 1 (cnt_a sticks at max),
    // plus repeated violations to saturate viol_cnt.
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(2, 1'b1, 1'b0);
    end
    for (int i = 0; i < CNT_MAX + 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);

    // Reset mid-guard, then a normal start-up.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(12, 1'b0, 1'b0);

    // Randomized traffic with occasional mode changes, clears and resets.
    md = 1'b0;
    sl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) md = ~md;
      sl = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 399) == 0),
           ($urandom_range(0, 2) == 0),
           md, sl,
           ($urandom_range(0, 7) == 0));
    end

    // Let the monitor consume the last expectation.
    @(negedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0, step_ctr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_demerge_t.md
PULSE_DEMERGE_T -- requirements
Module: pulse_demerge_t

Interface
- REQ-001: Parameter MIN_GAP, default 3; minimum clock cycles between accepted input pulses (legal range 1..15).
- REQ-002: Parameter BEGIN_CYC, default 8; number of start-up cycles after reset during which input pulses are ignored.
- REQ-003: Parameter CNT_W, default 16; width of every pulse and violation counter.
- REQ-004: clk  input  1  single clock; all state updates on the rising edge.
- REQ-005: rst  input  1  reset, synchronous and active-high.
- REQ-006: q_in  input  1  toggle-encoded merged pulse stream; each level change is one pulse.
- REQ-007: mode  input  1  steering mode; 0 = round-robin, 1 = steer by sel.
- REQ-008: sel  input  1  target in mode 1; 0 = output a, 1 = output b.
- REQ-009: viol_clr  input  1  clears the sticky viol flag.
- REQ-010: a_q  output  1  toggle-encoded pulse stream for branch a.
- REQ-011: b_q  output  1  toggle-encoded pulse stream for branch b.
- REQ-012: cnt_a, cnt_b  output  CNT_W  number of pulses steered to a and to b.
- REQ-013: viol  output  1  sticky flag; set when an input pulse arrives inside the guard window.
- REQ-014: viol_cnt  output  CNT_W  number of guard-window violations.
- REQ-015: ready  output  1  high while the block is in the ACTIVE or GUARD state.

Function
- REQ-016: Register q_prev holds q_in from the previous edge; a pulse is detected at an edge when q_in != q_prev.
- REQ-017: The state machine has three states: STARTUP, ACTIVE, GUARD.
- REQ-018: STARTUP: q_prev tracks q_in, and detected pulses are ignored without a violation. After BEGIN_CYC edges the block moves to ACTIVE.
- REQ-019: ACTIVE, pulse detected: the block accepts the pulse and toggles exactly one of a_q/b_q at that edge, giving 1-cycle latency.
- REQ-020: After an accepted pulse, the block enters GUARD if MIN_GAP > 1; otherwise it stays in ACTIVE.
- REQ-021: GUARD lasts MIN_GAP-1 edges, tracked by a down-counter, and then returns to ACTIVE.
- REQ-022: GUARD, pulse detected: the pulse is dropped with no output toggle. viol is set, viol_cnt increments, and the guard counter reloads to MIN_GAP-1.
- REQ-023: Round-robin steering: pointer rr starts at a. Each accepted pulse goes to rr, then rr flips. Dropped pulses do not advance rr.
- REQ-024: Mode 1 steering: an accepted pulse goes to sel as sampled at the accepting edge. rr does not move while mode = 1.
- REQ-025: Changing mode takes effect at the next edge. Returning to mode 0 resumes from the held rr value.
- REQ-026: Each accepted pulse increments cnt_a or cnt_b, matching the output it toggled.
- REQ-027: All counters saturate at 2^CNT_W-1 and never wrap.
- REQ-028: viol_clr clears viol at the edge. If a violation occurs at the same edge, viol stays 1 (violation wins). viol_cnt is never cleared by viol_clr.
- REQ-029: ready is 0 in STARTUP and 1 in ACTIVE and GUARD.

Reset
- REQ-030: When rst is high at an edge, the block goes to STARTUP and all of the following are zeroed: a_q, b_q, cnt_a, cnt_b, viol, viol_cnt, ready, q_prev, rr (= a), guard counter, startup counter.
- REQ-031: rst has priority over all other inputs. Reset mid-GUARD or mid-STARTUP aborts that state.
- REQ-032: Any q_in level present at reset release is absorbed in STARTUP and never produces a pulse.

Verification
- REQ-033: Start-up. Reset, then toggle q_in at cycles 2 and 5 after release (BEGIN_CYC=8) -> no a_q/b_q change, viol=0, ready rises at edge 8.
- REQ-034: Round-robin. mode=0, after ready, toggle q_in 4 times, 3 cycles apart -> a_q, b_q, a_q, b_q each toggle once per pulse at 1-cycle latency; cnt_a=2, cnt_b=2.
- REQ-035: Guard violation. MIN_GAP=3, pulses at cycles t and t+1 -> second pulse dropped, viol=1, viol_cnt=1. Pulse at t+3 is also dropped, because the guard reloaded at t+1. Pulse at t+4 is accepted.
- REQ-036: Steering. mode=1, sel=1, 3 legal pulses -> only b_q toggles, cnt_b=3. Then switch to mode=0 with rr=a -> next pulse goes to a.
- REQ-037: Clear race. viol=1; assert viol_clr on the same edge as a new violation -> viol stays 1, viol_cnt increments. viol_clr alone on the next edge -> viol=0.
- REQ-038: Saturation and reset. CNT_W=2, 5 legal pulses in mode 1 with sel=0 -> cnt_a stays at 3. Assert rst mid-GUARD -> all outputs 0 at the next edge, ready=0.
